// File: rtl/alu_pkg.sv
// Shared types for the pipelined ALU: operation codes and the flag bundle
// that travels alongside each result.
package alu_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_SHL = 3'b101,
    OP_SHR = 3'b110,
    OP_SLT = 3'b111
  } alu_op_e;

  typedef struct packed {
    logic zero;
    logic negative;
    logic carry;
    logic overflow;
  } alu_flags_t;

endpackage

// File: rtl/alu_core.sv
// Purely combinational ALU datapath: computes result and flags for one beat.
// Carry doubles as borrow for SUB; carry/overflow are zero for non-arithmetic ops.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  alu_op_e          op,
  output logic [WIDTH-1:0] result,
  output alu_flags_t       flags
);

  localparam int SHW = $clog2(WIDTH);
  localparam int MSB = WIDTH - 1;

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic [SHW-1:0]   shamt;

  assign sum   = {1'b0, a} + {1'b0, b};
  assign diff  = {1'b0, a} - {1'b0, b};
  assign shamt = b[SHW-1:0];

  // Select the operation result and derive every flag from it
  always_comb begin
    result         = '0;
    flags          = '0;
    case (op)
      OP_ADD: begin
        result         = sum[WIDTH-1:0];
        flags.carry    = sum[WIDTH];
        flags.overflow = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]);
      end
      OP_SUB: begin
        result         = diff[WIDTH-1:0];
        flags.carry    = diff[WIDTH];
        flags.overflow = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]);
      end
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      OP_XOR: result = a ^ b;
      OP_SHL: result = a << shamt;
      OP_SHR: result = a >> shamt;
      OP_SLT: result = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      default: result = '0;
    endcase
    flags.zero     = (result == '0);
    flags.negative = result[MSB];
  end

endmodule

// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU with valid/ready on both sides.
// S1 captures operands, S2 holds the computed result until the consumer takes it.
// A beat delivered with overflow sets a sticky status bit.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [OP_W-1:0]  op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             negative,
  output logic             carry,
  output logic             overflow,
  output logic             sticky_ovf,
  input  logic             clr_sticky
);

  logic             s1_valid;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  alu_op_e          s1_op;

  logic             s1_adv;
  logic             s2_adv;

  logic [WIDTH-1:0] core_result;
  alu_flags_t       core_flags;
  alu_flags_t       flags_q;

  assign s2_adv   = !out_valid || out_ready;
  assign s1_adv   = !s1_valid || s2_adv;
  assign in_ready = s1_adv;

  alu_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .a      (s1_a),
    .b      (s1_b),
    .op     (s1_op),
    .result (core_result),
    .flags  (core_flags)
  );

  // S1: capture an operand beat whenever the stage can move forward
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_op    <= OP_ADD;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_a  <= a;
        s1_b  <= b;
        s1_op <= alu_op_e'(op);
      end
    end
  end

  // S2: register the computed result; it stays put while the consumer stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      result    <= '0;
      flags_q   <= '0;
    end else if (s2_adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        result  <= core_result;
        flags_q <= core_flags;
      end
    end
  end

  // Sticky overflow: a delivered overflow beat beats a simultaneous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_ovf <= 1'b0;
    end else if (out_valid && out_ready && flags_q.overflow) begin
      sticky_ovf <= 1'b1;
    end else if (clr_sticky) begin
      sticky_ovf <= 1'b0;
    end
  end

  assign zero     = flags_q.zero;
  assign negative = flags_q.negative;
  assign carry    = flags_q.carry;
  assign overflow = flags_q.overflow;

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe (WIDTH=8): directed vector table, backpressure,
// mid-flight reset, sticky overflow handling and a randomized scoreboard run.
module tb_alu_pipe;

  typedef struct packed {
    logic [7:0] res;
    logic       z;
    logic       n;
    logic       c;
    logic       v;
  } exp_t;

  typedef struct {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    exp_t       e;
  } vec_t;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic [2:0] op;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] result;
  logic       zero;
  logic       negative;
  logic       carry;
  logic       overflow;
  logic       sticky_ovf;
  logic       clr_sticky;

  int   n_checks;
  int   n_fails;
  exp_t sb[$];
  logic sticky_model;
  logic last_in_tx;
  logic last_out_tx;

  alu_pipe #(
    .WIDTH (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .op         (op),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .zero       (zero),
    .negative   (negative),
    .carry      (carry),
    .overflow   (overflow),
    .sticky_ovf (sticky_ovf),
    .clr_sticky (clr_sticky)
  );

  // Free-running 10 ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Global watchdog so a hung handshake can never stall the run forever
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference model: plain integer arithmetic on unsigned and signed views of the operands
  function automatic exp_t model(input logic [2:0] mop, input logic [7:0] ma, input logic [7:0] mb);
    exp_t e;
    int ua, ub, sa, sb_i, r, amt;
    ua   = int'(ma);
    ub   = int'(mb);
    sa   = (ua >= 128) ? ua - 256 : ua;
    sb_i = (ub >= 128) ? ub - 256 : ub;
    amt  = ub % 8;
    e    = '0;
    r    = 0;
    case (mop)
      3'd0: begin
        r   = ua + ub;
        e.c = (r > 255);
        e.v = ((sa + sb_i) > 127) || ((sa + sb_i) < -128);
      end
      3'd1: begin
        r   = ua - ub;
        e.c = (ua < ub);
        e.v = ((sa - sb_i) > 127) || ((sa - sb_i) < -128);
      end
      3'd2: r = ua & ub;
      3'd3: r = ua | ub;
      3'd4: r = ua ^ ub;
      3'd5: r = ua * (1 << amt);
      3'd6: r = ua / (1 << amt);
      default: r = (sa < sb_i) ? 1 : 0;
    endcase
    e.res = r[7:0];
    e.z   = (e.res == 8'h00);
    e.n   = (e.res >= 8'h80);
    return e;
  endfunction

  // One comparison: counts it and reports any mismatch
  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] required);
    n_checks++;
    if (actual !== required) begin
      n_fails++;
      $display("[TB] FAIL %s: actual=0x%0h required=0x%0h at %0t", name, actual, required, $time);
    end
  endtask

  // One clock cycle: drive inputs after the falling edge, then sample, score transfers and track sticky
  task automatic applyStimulus(input logic iv, input logic [2:0] iop, input logic [7:0] ia,
                               input logic [7:0] ib, input logic ordy, input logic clr,
                               input exp_t exp_in);
    exp_t e;
    logic set_now;
    @(negedge clk);
    in_valid   = iv;
    op         = iop;
    a          = ia;
    b          = ib;
    out_ready  = ordy;
    clr_sticky = clr;
    #1;
    last_in_tx  = in_valid && in_ready;
    last_out_tx = out_valid && out_ready;
    set_now     = 1'b0;
    checkOutput("sticky_ovf", sticky_ovf, sticky_model);
    if (last_out_tx) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_beat", 1, 0);
      end else begin
        e = sb.pop_front();
        checkOutput("result", result, e.res);
        checkOutput("flags_zncv", {zero, negative, carry, overflow}, {e.z, e.n, e.c, e.v});
        set_now = e.v;
      end
    end
    if (last_in_tx) sb.push_back(exp_in);
    if (set_now) sticky_model = 1'b1;
    else if (clr) sticky_model = 1'b0;
  endtask

  vec_t vecs[$];
  logic [7:0] bp_a[4];
  logic [7:0] bp_b[4];

  // Main sequence: reset, directed table, backpressure, sticky, mid-flight reset, random traffic
  initial begin
    int lat, accepted, delivered, cycles;
    logic [2:0] rop;
    logic [7:0] ra, rb;
    n_checks     = 0;
    n_fails      = 0;
    sticky_model = 1'b0;
    last_in_tx   = 1'b0;
    last_out_tx  = 1'b0;
    rst_n        = 1'b0;
    in_valid     = 1'b0;
    a            = '0;
    b            = '0;
    op           = '0;
    out_ready    = 1'b0;
    clr_sticky   = 1'b0;

    vecs.push_back('{3'd0, 8'hFF, 8'h01, '{8'h00, 1'b1, 1'b0, 1'b1, 1'b0}});
    vecs.push_back('{3'd1, 8'h80, 8'h01, '{8'h7F, 1'b0, 1'b0, 1'b0, 1'b1}});
    vecs.push_back('{3'd1, 8'h01, 8'h02, '{8'hFF, 1'b0, 1'b1, 1'b1, 1'b0}});
    vecs.push_back('{3'd7, 8'hFE, 8'h01, '{8'h01, 1'b0, 1'b0, 1'b0, 1'b0}});
    vecs.push_back('{3'd7, 8'h01, 8'hFE, '{8'h00, 1'b1, 1'b0, 1'b0, 1'b0}});
    vecs.push_back('{3'd5, 8'h81, 8'h09, '{8'h02, 1'b0, 1'b0, 1'b0, 1'b0}});
    vecs.push_back('{3'd6, 8'h80, 8'h07, '{8'h01, 1'b0, 1'b0, 1'b0, 1'b0}});
    vecs.push_back('{3'd6, 8'h5A, 8'h08, '{8'h5A, 1'b0, 1'b0, 1'b0, 1'b0}});
    vecs.push_back('{3'd2, 8'hF0, 8'h3C, '{8'h30, 1'b0, 1'b0, 1'b0, 1'b0}});
    vecs.push_back('{3'd3, 8'h0F, 8'hF0, '{8'hFF, 1'b0, 1'b1, 1'b0, 1'b0}});
    vecs.push_back('{3'd4, 8'hAA, 8'hAA, '{8'h00, 1'b1, 1'b0, 1'b0, 1'b0}});
    vecs.push_back('{3'd0, 8'h7F, 8'h01, '{8'h80, 1'b0, 1'b1, 1'b0, 1'b1}});

    #12;
    checkOutput("reset_out_valid", out_valid, 0);
    checkOutput("reset_result", result, 0);
    checkOutput("reset_flags", {zero, negative, carry, overflow}, 4'b0000);
    checkOutput("reset_sticky", sticky_ovf, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("reset_in_ready", in_ready, 1);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(1'b1, vecs[i].op, vecs[i].a, vecs[i].b, 1'b1, 1'b0, vecs[i].e);
      lat = 0;
      while (!last_out_tx && lat < 6) begin
        applyStimulus(1'b0, 3'd0, 8'h00, 8'h00, 1'b1, 1'b0, '0);
        lat++;
      end
      checkOutput("latency", lat, 2);
    end

    bp_a = '{8'h10, 8'h20, 8'h30, 8'h40};
    bp_b = '{8'h01, 8'h02, 8'h03, 8'h04};
    accepted = 0;
    cycles   = 0;
    while (accepted < 2 && cycles < 6) begin
      applyStimulus(1'b1, 3'd0, bp_a[accepted], bp_b[accepted], 1'b0, 1'b0,
                    model(3'd0, bp_a[accepted], bp_b[accepted]));
      if (last_in_tx) accepted++;
      cycles++;
    end
    checkOutput("bp_accepted_two", accepted, 2);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, 3'd0, bp_a[2], bp_b[2], 1'b0, 1'b0, model(3'd0, bp_a[2], bp_b[2]));
      if (last_in_tx) accepted++;
      checkOutput("bp_in_ready_low", in_ready, 0);
      checkOutput("bp_out_valid_held", out_valid, 1);
      checkOutput("bp_result_held", result, 8'h11);
    end
    delivered = 0;
    cycles    = 0;
    while (delivered < 4 && cycles < 10) begin
      applyStimulus(accepted < 4, 3'd0, bp_a[accepted < 4 ? accepted : 0], bp_b[accepted < 4 ? accepted : 0],
                    1'b1, 1'b0, model(3'd0, bp_a[accepted < 4 ? accepted : 0], bp_b[accepted < 4 ? accepted : 0]));
      if (last_in_tx) accepted++;
      if (last_out_tx) delivered++;
      cycles++;
    end
    checkOutput("bp_delivered", delivered, 4);
    checkOutput("bp_drain_cycles", cycles, 4);

    applyStimulus(1'b0, 3'd0, 8'h00, 8'h00, 1'b1, 1'b1, '0);
    applyStimulus(1'b1, 3'd1, 8'h80, 8'h01, 1'b1, 1'b0, model(3'd1, 8'h80, 8'h01));
    applyStimulus(1'b0, 3'd0, 8'h00, 8'h00, 1'b1, 1'b0, '0);
    applyStimulus(1'b0, 3'd0, 8'h00, 8'h00, 1'b1, 1'b1, '0);
    checkOutput("sticky_ovf_beat_transfers", last_out_tx, 1);
    applyStimulus(1'b0, 3'd0, 8'h00, 8'h00, 1'b1, 1'b1, '0);
    checkOutput("sticky_set_wins", sticky_ovf, 1);
    applyStimulus(1'b0, 3'd0, 8'h00, 8'h00, 1'b1, 1'b0, '0);
    checkOutput("sticky_cleared", sticky_ovf, 0);

    applyStimulus(1'b1, 3'd1, 8'h80, 8'h01, 1'b1, 1'b0, model(3'd1, 8'h80, 8'h01));
    applyStimulus(1'b1, 3'd0, 8'h05, 8'h06, 1'b1, 1'b0, model(3'd0, 8'h05, 8'h06));
    in_valid = 1'b0;
    @(posedge clk);
    #2;
    checkOutput("rst_mid_in_flight", out_valid, 1);
    rst_n = 1'b0;
    #1;
    checkOutput("rst_mid_out_valid", out_valid, 0);
    checkOutput("rst_mid_result", result, 0);
    checkOutput("rst_mid_flags", {zero, negative, carry, overflow}, 4'b0000);
    sb.delete();
    sticky_model = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b0, 3'd0, 8'h00, 8'h00, 1'b1, 1'b0, '0);
      checkOutput("rst_mid_no_stale", out_valid, 0);
      checkOutput("rst_mid_in_ready", in_ready, 1);
    end

    for (int k = 0; k < 400; k++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = 8'($urandom);
      rb  = 8'($urandom);
      applyStimulus($urandom_range(0, 9) < 7, rop, ra, rb, $urandom_range(0, 9) < 7,
                    $urandom_range(0, 9) == 0, model(rop, ra, rb));
    end
    cycles = 0;
    while (sb.size() > 0 && cycles < 10) begin
      applyStimulus(1'b0, 3'd0, 8'h00, 8'h00, 1'b1, 1'b0, '0);
      cycles++;
    end
    checkOutput("random_drain_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
- Parametrised, two-stage pipelined ALU; successor to the 4-bit combinational ALU.
- Adds configurable operand width, an 8-operation set, a full flag set (zero, negative, carry, overflow), valid/ready handshakes on both sides with backpressure, and a sticky overflow status.
- Sits between an operand source (sequencer or test stimulus) and a result consumer. Both ends use the same valid/ready protocol.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..64.
- SHW, $clog2(WIDTH), derived (localparam): number of shift-amount bits taken from b.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block can accept an operand beat.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B; bits [SHW-1:0] give the shift amount for SHL/SHR.
- op  in  3  operation code.
- out_valid  out  1  result beat valid.
- out_ready  in  1  consumer accepts the result beat.
- result  out  WIDTH  operation result.
- zero  out  1  result == 0.
- negative  out  1  result[WIDTH-1].
- carry  out  1  unsigned carry (ADD) or borrow (SUB); 0 for all other ops.
- overflow  out  1  signed overflow (ADD/SUB); 0 for all other ops.
- sticky_ovf  out  1  set by any delivered overflow; cleared by clr_sticky.
- clr_sticky  in  1  clears sticky_ovf.

Behaviour:
- Reset (async, rst_n=0):
  - both stage-valid bits, out_valid, result, all flags and sticky_ovf go to 0.
  - in_ready goes to 1 once rst_n deasserts.
  - Any beats in flight are discarded, not delivered.
- Handshake:
  - An input beat transfers when in_valid && in_ready.
  - An output beat transfers when out_valid && out_ready.
  - out_valid, result and flags hold stable until the output transfers.
- Pipeline:
  - S1 registers a, b and op. S2 computes the result and registers result and flags.
  - s2_adv = !out_valid || out_ready.
  - s1_adv = !s1_valid || s2_adv.
  - in_ready = s1_adv, a combinational function of registered state and out_ready.
  - Latency: 2 cycles from input transfer to out_valid with no stall. Throughput: 1 beat/cycle.
  - Under stall, at most 2 beats are held. Order is preserved; no beat is dropped or duplicated.
- Op codes (3'bxxx):
  - 000 ADD: {carry,result} = a + b (WIDTH+1 bits). overflow = (a[msb]==b[msb]) && (result[msb]!=a[msb]).
  - 001 SUB: result = a - b. carry = (a < b) unsigned, i.e. borrow. overflow = (a[msb]!=b[msb]) && (result[msb]!=a[msb]).
  - 010 AND; 011 OR; 100 XOR.
  - 101 SHL: a << b[SHW-1:0], zero fill.
  - 110 SHR: a >> b[SHW-1:0], logical, zero fill. Higher bits of b are ignored. A shift by 0 passes a through.
  - 111 SLT: result = 1 if $signed(a) < $signed(b), else 0.
  - zero and negative are computed for every op.
- sticky_ovf:
  - Set on the cycle an output beat with overflow=1 transfers.
  - Cleared when clr_sticky=1.
  - If set and clear occur in the same cycle, set wins.
- X-safety: when in_valid=0, S1 data registers need not update. Flags are never X after reset.

Decomposition:
- Package alu_pkg holds:
  - op enum alu_op_e (OP_ADD..OP_SLT, 3 bits);
  - a flags struct {zero, negative, carry, overflow}.
- One sub-module, alu_core: a purely combinational compute (a, b, op -> result, flags), parametrised by WIDTH and instantiated in S2.
- Pipeline registers and the handshake stay in alu_pipe.

Test Plan:
- All tests use WIDTH=8.
- ADD 0xFF + 0x01, out_ready=1 -> after 2 cycles: result=0x00, zero=1, carry=1, overflow=0, negative=0.
- SUB 0x80 - 0x01 -> result=0x7F, overflow=1, carry=0; sticky_ovf=1 the next cycle. Then SUB 0x01 - 0x02 -> result=0xFF, carry=1, negative=1.
- SLT a=0xFE (-2), b=0x01 -> result=0x01. SHL 0x81 by b=0x09 (amount 1) -> result=0x02. SHR 0x80 by 7 -> result=0x01.
- Backpressure: hold out_ready=0 and present 4 back-to-back beats. in_ready falls after 2 are accepted; out_valid and result stay stable. Release out_ready -> all 4 results arrive in order, one per cycle, none lost or duplicated.
- Reset mid-operation: deassert rst_n asynchronously with 2 beats in flight. Outputs go to 0 immediately; after release no stale beat appears and in_ready=1.
- Sticky: an overflow beat transfers on the same cycle clr_sticky=1 -> sticky_ovf=1. clr_sticky alone next cycle -> sticky_ovf=0.
